fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Control-state sequencer directly upstream of the RAM byte reader; it generates the 3-bit control state `cs` that the reader consumes.
- Owns the program counter and the opcode register.
- Chooses the RAM address fed to the reader and advances state on the reader's `kp` (keep-reading) signal.
- Flags instruction completion, halt, and stalled reads.

Parameters:
- RESET_PC, 16'h0000, program counter value after reset
- INSN_LEN, 8, bytes per instruction (1 opcode + 7 operand bytes); added to pc on leaving OPLRD
- MAXW, 8, watchdog limit: max consecutive cycles with kp=1 in OPLRD or EXERD

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- kp  in  1  reader busy; 1 = more bytes to read
- d  in  8  RAM read data at current address
- oprnd  in  16  low 16 bits of reader's assembled operand (memory address for read-class opcodes)
- cs  out  3  control state to reader: OPCFT, OPLRD, ADRD, EXERD, EXE, HLT, ERR
- add  out  16  address to reader; combinational: oprnd when cs=ADRD, else pc
- opc  out  8  latched opcode, also fed to reader
- pc  out  16  program counter
- exe_stb  out  1  one-cycle pulse in EXE
- halted  out  1  1 while cs=HLT
- err  out  1  1 while cs=ERR

Behaviour:
- Reset (rst_n=0 at posedge): cs=OPCFT, pc=RESET_PC, opc=8'h00, watchdog count=0. Outputs derived from these: add=pc, exe_stb=0, halted=0, err=0. Reset overrides every state, including HLT/ERR and mid-read.
- OPCFT: lasts exactly 1 cycle. add=pc. At the posedge, opc<=d. Next state is OPLRD.
- OPLRD: hold while kp=1. At the first posedge sampling kp=0:
  - pc<=pc+INSN_LEN, modulo 2^16 (0xFFF8+8 wraps to 0x0000).
  - Next state, using the opc latched in OPCFT:
    - HALT -> HLT.
    - Read-class (POP, MOVRA, MOVRA4, MOVRA1) -> ADRD.
    - Otherwise -> EXE.
- ADRD: lasts exactly 1 cycle. add=oprnd. Next state is EXERD.
- EXERD: hold while kp=1; on kp=0 go to EXE. MOVRA1 causes 1 cycle of EXERD, since the reader drops kp immediately.
- EXE: lasts 1 cycle. exe_stb=1. Next state is OPCFT.
- HLT: absorbing; halted=1; pc frozen; only reset leaves.
- Watchdog:
  - Count clears on entering OPLRD or EXERD.
  - Increments each cycle in those states with kp=1.
  - When count reaches MAXW with kp still 1, go to ERR instead of holding.
- ERR: absorbing; err=1; only reset leaves.
- Outputs cs, opc, pc are registered. add, exe_stb, halted, err decode from cs with no extra latency.
- kp is ignored in OPCFT, ADRD, EXE, HLT, ERR.

Decomposition:
- Shared header holds the state codes (OPCFT, ADRD, OPLRD, EXERD, plus new EXE, HLT, ERR, all 3-bit, distinct) and the opcode constants (POP, MOVRA, MOVRA4, MOVRA1, plus new HALT). The reader includes the same header.
- One natural sub-module: `opclass`, combinational, mapping opc to {is_read, is_halt}; reusable by the future decoder.
- Watchdog counter stays inline.

Test Plan:
- Reset check: rst_n=0 for 2 cycles, release -> cs=OPCFT, add=0000, pc=0000, exe_stb=0. Next cycle cs=OPLRD, opc=d sampled in OPCFT.
- Non-read opcode: d=8'h01 in OPCFT, kp=1 for 6 cycles then 0 -> 1 OPCFT cycle, 7 OPLRD cycles, 1 EXE cycle (exe_stb=1), then OPCFT with pc=0008.
- Read-class path: opc=MOVRA, oprnd=16'h1234, OPLRD kp high 6 cycles, EXERD kp high 7 cycles ->
  - ADRD for 1 cycle with add=1234.
  - 8 EXERD cycles, then EXE with add=pc=0008.
  - Repeat with MOVRA1 and kp=0 -> EXERD lasts exactly 1 cycle.
- Halt: opc=HALT, OPLRD kp drops -> cs=HLT and halted=1 for 20 further cycles; pc=0008 constant. rst_n pulse -> OPCFT, pc=0000.
- Watchdog: kp held 1 in OPLRD with MAXW=8 -> ERR entered at the posedge after the 8th kp=1 cycle, err=1 sticky. Same check in EXERD.
- Wrap and mid-read reset:
  - RESET_PC=16'hFFF8, non-read instruction -> pc=0000 after OPLRD.
  - rst_n=0 on the 3rd EXERD cycle -> next cycle cs=OPCFT, pc=RESET_PC, exe_stb never asserted.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the RAM byte reader:
// control-state codes and opcode constants.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        OPCFT = 3'd0,
        OPLRD = 3'd1,
        ADRD  = 3'd2,
        EXERD = 3'd3,
        EXE   = 3'd4,
        HLT   = 3'd5,
        ERR   = 3'd6
    } state_t;

    // The read-class opcodes carry a memory address in their operand.
    localparam logic [7:0] POP    = 8'h10;
    localparam logic [7:0] MOVRA  = 8'h20;
    localparam logic [7:0] MOVRA4 = 8'h21;
    localparam logic [7:0] MOVRA1 = 8'h22;
    localparam logic [7:0] HALT   = 8'hFF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Sequencer <-> reader link: control state, address and opcode one way,
// keep-reading flag, RAM data and assembled operand the other.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    state_t      cs;
    logic [15:0] add;
    logic [7:0]  opc;
    logic        kp;
    logic [7:0]  d;
    logic [15:0] oprnd;

    modport master (output cs, add, opc, input kp, d, oprnd);
    modport slave  (input cs, add, opc, output kp, d, oprnd);

endinterface

// File: rtl/fetch_sequencer_opclass.sv
// Combinational opcode classifier; shared with the future decoder.
module fetch_sequencer_opclass
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opc,
    output logic       is_read,
    output logic       is_halt
);

    always_comb begin
        is_read = 1'b0;
        is_halt = 1'b0;
        case (opc)
            POP, MOVRA, MOVRA4, MOVRA1: is_read = 1'b1;
            HALT:                       is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Control-state sequencer ahead of the RAM byte reader: owns pc and opcode,
// picks the read address and steps on the reader's keep-reading flag.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          INSN_LEN = 8,
    parameter int          MAXW     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus,
    output logic [15:0]        pc,
    output logic               exe_stb,
    output logic               halted,
    output logic               err
);

    localparam int WDW = $clog2(MAXW + 1);

    state_t         state;
    logic [7:0]     opc_q;
    logic [WDW-1:0] wd_cnt;
    logic           is_read;
    logic           is_halt;

    fetch_sequencer_opclass u_opclass (
        .opc     (opc_q),
        .is_read (is_read),
        .is_halt (is_halt)
    );

    // The watchdog is cleared on every transition into a kp-waiting state;
    // the MAXW-th consecutive busy cycle trips it instead of holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= OPCFT;
            pc     <= RESET_PC;
            opc_q  <= 8'h00;
            wd_cnt <= '0;
        end else begin
            case (state)
                OPCFT: begin
                    opc_q  <= bus.d;
                    wd_cnt <= '0;
                    state  <= OPLRD;
                end
                OPLRD: begin
                    if (bus.kp) begin
                        if (wd_cnt == WDW'(MAXW - 1)) state <= ERR;
                        else                          wd_cnt <= wd_cnt + WDW'(1);
                    end else begin
                        pc <= pc + 16'(INSN_LEN);
                        if (is_halt)      state <= HLT;
                        else if (is_read) state <= ADRD;
                        else              state <= EXE;
                    end
                end
                ADRD: begin
                    wd_cnt <= '0;
                    state  <= EXERD;
                end
                EXERD: begin
                    if (bus.kp) begin
                        if (wd_cnt == WDW'(MAXW - 1)) state <= ERR;
                        else                          wd_cnt <= wd_cnt + WDW'(1);
                    end else begin
                        state <= EXE;
                    end
                end
                EXE:     state <= OPCFT;
                HLT:     state <= HLT;
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

    assign bus.cs  = state;
    assign bus.opc = opc_q;
    assign bus.add = (state == ADRD) ? bus.oprnd : pc;
    assign exe_stb = (state == EXE);
    assign halted  = (state == HLT);
    assign err     = (state == ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer; a second instance with
// RESET_PC=16'hFFF8 runs in lockstep to exercise pc wrap-around.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    typedef struct packed {
        state_t      cs;
        logic [15:0] add;
        logic [7:0]  opc;
        logic [15:0] pc;
        logic        stb;
        logic        hlt;
        logic        er;
    } snap_t;

    typedef struct packed {
        snap_t a;
        snap_t b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        kp;
    logic [7:0]  d;
    logic [15:0] oprnd;
    logic [15:0] pc1, pc2;
    logic        stb1, stb2, hlt1, hlt2, err1, err2;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fetch_sequencer_if bus1();
    fetch_sequencer_if bus2();

    assign bus1.kp    = kp;
    assign bus1.d     = d;
    assign bus1.oprnd = oprnd;
    assign bus2.kp    = kp;
    assign bus2.d     = d;
    assign bus2.oprnd = oprnd;

    fetch_sequencer #(.RESET_PC(16'h0000), .INSN_LEN(8), .MAXW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1.master),
        .pc      (pc1),
        .exe_stb (stb1),
        .halted  (hlt1),
        .err     (err1)
    );

    fetch_sequencer #(.RESET_PC(16'hFFF8), .INSN_LEN(8), .MAXW(8)) dut_wrap (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus2.master),
        .pc      (pc2),
        .exe_stb (stb2),
        .halted  (hlt2),
        .err     (err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Push the expected outputs for the current cycle, drive the inputs the
    // next edge samples, then move to just after that edge.
    task automatic applyStimulus(input logic r, input logic k, input logic [7:0] dv,
                                 input logic [15:0] ov, input state_t ecs,
                                 input logic [15:0] eadd, input logic [7:0] eopc,
                                 input logic [15:0] epc);
        exp_t e;
        e.a.cs  = ecs;
        e.a.add = eadd;
        e.a.opc = eopc;
        e.a.pc  = epc;
        e.a.stb = (ecs == EXE);
        e.a.hlt = (ecs == HLT);
        e.a.er  = (ecs == ERR);
        e.b     = e.a;
        e.b.pc  = epc + 16'hFFF8;
        e.b.add = (ecs == ADRD) ? eadd : epc + 16'hFFF8;
        q.push_back(e);
        rst_n = r;
        kp    = k;
        d     = dv;
        oprnd = ov;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input snap_t act, input snap_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got cs=%0d add=%h opc=%h pc=%h stb=%b hlt=%b err=%b want cs=%0d add=%h opc=%h pc=%h stb=%b hlt=%b err=%b",
                     name, cyc, act.cs, act.add, act.opc, act.pc, act.stb, act.hlt, act.er,
                     exp.cs, exp.add, exp.opc, exp.pc, exp.stb, exp.hlt, exp.er);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-period.
    initial begin
        exp_t  e;
        snap_t a1, a2;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a1.cs = bus1.cs; a1.add = bus1.add; a1.opc = bus1.opc; a1.pc = pc1;
                a1.stb = stb1;   a1.hlt = hlt1;     a1.er = err1;
                a2.cs = bus2.cs; a2.add = bus2.add; a2.opc = bus2.opc; a2.pc = pc2;
                a2.stb = stb2;   a2.hlt = hlt2;     a2.er = err2;
                checkOutput("pc0000", a1, e.a);
                checkOutput("pcfff8", a2, e.b);
                cyc++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        kp    = 1'b0;
        d     = 8'h00;
        oprnd = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("[TB] reset and non-read opcode");
        applyStimulus(1'b1, 1'b0, 8'h01, 16'h0000, OPCFT, 16'h0000, 8'h00, 16'h0000);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h0000, OPLRD, 16'h0000, 8'h01, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, OPLRD, 16'h0000, 8'h01, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, EXE,   16'h0008, 8'h01, 16'h0008);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, OPCFT, 16'h0008, 8'h01, 16'h0008);

        $display("[TB] read-class MOVRA then MOVRA1");
        applyStimulus(1'b1, 1'b0, MOVRA, 16'h1234, OPCFT, 16'h0000, 8'h00, 16'h0000);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h1234, OPLRD, 16'h0000, MOVRA, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h1234, OPLRD, 16'h0000, MOVRA, 16'h0000);
        applyStimulus(1'b1, 1'b1, 8'h00, 16'h1234, ADRD,  16'h1234, MOVRA, 16'h0008);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h1234, EXERD, 16'h0008, MOVRA, 16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h1234, EXERD, 16'h0008, MOVRA, 16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h1234, EXE,   16'h0008, MOVRA, 16'h0008);
        applyStimulus(1'b1, 1'b0, MOVRA1, 16'h00AB, OPCFT, 16'h0008, MOVRA,  16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h00AB, OPLRD, 16'h0008, MOVRA1, 16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h00AB, ADRD,  16'h00AB, MOVRA1, 16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h00AB, EXERD, 16'h0010, MOVRA1, 16'h0010);
        applyStimulus(1'b1, 1'b1, 8'h00,  16'h00AB, EXE,   16'h0010, MOVRA1, 16'h0010);
        applyStimulus(1'b0, 1'b1, 8'h00,  16'h0000, OPCFT, 16'h0010, MOVRA1, 16'h0010);

        $display("[TB] halt is absorbing until reset");
        applyStimulus(1'b1, 1'b1, HALT,  16'h0000, OPCFT, 16'h0000, 8'h00, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, OPLRD, 16'h0000, HALT,  16'h0000);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'(i % 2), 8'h00, 16'h0000, HLT, 16'h0008, HALT, 16'h0008);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, HLT, 16'h0008, HALT, 16'h0008);

        $display("[TB] opcode classes POP, MOVRA4, plain 0x23");
        applyStimulus(1'b1, 1'b0, POP,    16'hBEEF, OPCFT, 16'h0000, 8'h00,  16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'hBEEF, OPLRD, 16'h0000, POP,    16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'hBEEF, ADRD,  16'hBEEF, POP,    16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'hBEEF, EXERD, 16'h0008, POP,    16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'hBEEF, EXE,   16'h0008, POP,    16'h0008);
        applyStimulus(1'b1, 1'b0, MOVRA4, 16'h4321, OPCFT, 16'h0008, POP,    16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, OPLRD, 16'h0008, MOVRA4, 16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, ADRD,  16'h4321, MOVRA4, 16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, EXERD, 16'h0010, MOVRA4, 16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, EXE,   16'h0010, MOVRA4, 16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h23,  16'h4321, OPCFT, 16'h0010, MOVRA4, 16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, OPLRD, 16'h0010, 8'h23,  16'h0010);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h4321, EXE,   16'h0018, 8'h23,  16'h0018);
        applyStimulus(1'b0, 1'b0, 8'h00,  16'h0000, OPCFT, 16'h0018, 8'h23,  16'h0018);

        $display("[TB] watchdog trips in OPLRD");
        applyStimulus(1'b1, 1'b0, 8'h01, 16'h0000, OPCFT, 16'h0000, 8'h00, 16'h0000);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h0000, OPLRD, 16'h0000, 8'h01, 16'h0000);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, ERR, 16'h0000, 8'h01, 16'h0000);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, ERR, 16'h0000, 8'h01, 16'h0000);

        $display("[TB] watchdog trips in EXERD after fresh count");
        applyStimulus(1'b1, 1'b0, MOVRA, 16'h5555, OPCFT, 16'h0000, 8'h00, 16'h0000);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h5555, OPLRD, 16'h0000, MOVRA, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h5555, OPLRD, 16'h0000, MOVRA, 16'h0000);
        applyStimulus(1'b1, 1'b1, 8'h00, 16'h5555, ADRD,  16'h5555, MOVRA, 16'h0008);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 8'h00, 16'h5555, EXERD, 16'h0008, MOVRA, 16'h0008);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, ERR, 16'h0008, MOVRA, 16'h0008);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, ERR, 16'h0008, MOVRA, 16'h0008);

        $display("[TB] reset in the middle of EXERD");
        applyStimulus(1'b1, 1'b0, MOVRA4, 16'h0777, OPCFT, 16'h0000, 8'h00,  16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h0777, OPLRD, 16'h0000, MOVRA4, 16'h0000);
        applyStimulus(1'b1, 1'b1, 8'h00,  16'h0777, ADRD,  16'h0777, MOVRA4, 16'h0008);
        applyStimulus(1'b1, 1'b1, 8'h00,  16'h0777, EXERD, 16'h0008, MOVRA4, 16'h0008);
        applyStimulus(1'b1, 1'b1, 8'h00,  16'h0777, EXERD, 16'h0008, MOVRA4, 16'h0008);
        applyStimulus(1'b0, 1'b1, 8'h00,  16'h0777, EXERD, 16'h0008, MOVRA4, 16'h0008);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h0000, OPCFT, 16'h0000, 8'h00,  16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h0000, OPLRD, 16'h0000, 8'h00,  16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00,  16'h0000, EXE,   16'h0008, 8'h00,  16'h0008);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
